// File: rtl/timer_scheduler_pkg.sv
// Shared register map, control/status bit positions and channel state encoding
// for the timer scheduler.
package timer_scheduler_pkg;

    localparam int unsigned MaxCh = 4;

    localparam logic [3:0] AddrPrescale = 4'd0;
    localparam logic [3:0] AddrCtrl     = 4'd1;
    localparam logic [3:0] AddrIrqClr   = 4'd2;
    localparam logic [3:0] AddrMode     = 4'd3;
    localparam logic [3:0] AddrReload0  = 4'd4;
    localparam logic [3:0] AddrReload1  = 4'd5;
    localparam logic [3:0] AddrReload2  = 4'd6;
    localparam logic [3:0] AddrReload3  = 4'd7;
    localparam logic [3:0] AddrCount0   = 4'd8;
    localparam logic [3:0] AddrCount1   = 4'd9;
    localparam logic [3:0] AddrCount2   = 4'd10;
    localparam logic [3:0] AddrCount3   = 4'd11;
    localparam logic [3:0] AddrStatus   = 4'd12;

    localparam int unsigned CtrlStartLsb = 0;
    localparam int unsigned CtrlStopLsb  = 4;
    localparam int unsigned StatusRunLsb = 0;
    localparam int unsigned StatusIrqLsb = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ch_state_e;

    // RELOAD and COUNT banks each occupy an aligned group of four addresses.
    function automatic logic is_reload_addr(input logic [3:0] addr);
        return addr[3:2] == AddrReload0[3:2];
    endfunction

    function automatic logic is_count_addr(input logic [3:0] addr);
        return addr[3:2] == AddrCount0[3:2];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN state, down-counter, reload value and pending IRQ.
module timer_channel
    import timer_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             tick_i,
    input  logic             periodic_i,
    input  logic             reload_we_i,
    input  logic [CNT_W-1:0] reload_data_i,
    input  logic             irq_clr_i,
    output logic             run_o,
    output logic             run_next_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] reload_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             irq_q, irq_d;
    logic             expire;

    assign expire = (state_q == StRun) && tick_i && (count_q == '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_we_i ? reload_data_i : reload_q;
        irq_d    = irq_q;

        if (irq_clr_i) begin
            irq_d = 1'b0;
        end
        if (expire) begin
            irq_d = 1'b1;
        end

        if ((state_q == StRun) && tick_i) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else if (periodic_i) begin
                count_d = reload_q;
            end else begin
                state_d = StIdle;
                count_d = '0;
            end
        end

        // Start overrides a coincident expiry; stop then overrides both and freezes COUNT.
        if (start_i) begin
            state_d = StRun;
            count_d = reload_q;
        end
        if (stop_i) begin
            state_d = StIdle;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
        end
    end

    assign run_o      = (state_q == StRun);
    assign run_next_o = (state_d == StRun);
    assign irq_o      = irq_q;
    assign count_o    = count_q;
    assign reload_o   = reload_q;

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel timer: shared prescaler, register decode and readback around
// per-channel timer_channel instances.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PRE_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR_EN,
    input  logic [3:0]        WR_ADDR,
    input  logic [CNT_W-1:0]  WR_DATA,
    input  logic [3:0]        RD_ADDR,
    output logic [CNT_W-1:0]  RD_DATA,
    output logic              TICK_OUT,
    output logic [NUM_CH-1:0] IRQ
);

    logic [7:0]        wr_byte;
    logic              wr_prescale, wr_ctrl, wr_irq_clr, wr_mode;
    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic              pre_en;
    logic [7:0]        status;

    logic [MaxCh-1:0]  run_ext, run_next_ext, irq_ext;
    logic [CNT_W-1:0]  reload_ext [MaxCh];
    logic [CNT_W-1:0]  count_ext  [MaxCh];

    assign wr_byte    = 8'(WR_DATA);
    assign wr_prescale = WR_EN && (WR_ADDR == AddrPrescale);
    assign wr_ctrl     = WR_EN && (WR_ADDR == AddrCtrl);
    assign wr_irq_clr  = WR_EN && (WR_ADDR == AddrIrqClr);
    assign wr_mode     = WR_EN && (WR_ADDR == AddrMode);

    for (genvar i = 0; i < MaxCh; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic reload_we;
            assign reload_we = WR_EN && is_reload_addr(WR_ADDR) && (WR_ADDR[1:0] == 2'(i));

            timer_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk_i        (CLK),
                .rst_i        (RESET),
                .start_i      (wr_ctrl && wr_byte[CtrlStartLsb + i]),
                .stop_i       (wr_ctrl && wr_byte[CtrlStopLsb + i]),
                .tick_i       (tick_q),
                .periodic_i   (mode_q[i]),
                .reload_we_i  (reload_we),
                .reload_data_i(WR_DATA),
                .irq_clr_i    (wr_irq_clr && wr_byte[i]),
                .run_o        (run_ext[i]),
                .run_next_o   (run_next_ext[i]),
                .irq_o        (irq_ext[i]),
                .count_o      (count_ext[i]),
                .reload_o     (reload_ext[i])
            );
        end else begin : g_off
            assign run_ext[i]      = 1'b0;
            assign run_next_ext[i] = 1'b0;
            assign irq_ext[i]      = 1'b0;
            assign count_ext[i]    = '0;
            assign reload_ext[i]   = '0;
        end
    end

    // Enabling on the next-state run flags lets the prescaler start counting in
    // the same edge that starts a channel, so the first period is a full one.
    assign pre_en = |run_next_ext;

    always_comb begin
        prescale_d = wr_prescale ? PRE_W'(WR_DATA) : prescale_q;
        mode_d     = wr_mode ? wr_byte[NUM_CH-1:0] : mode_q;
        tick_d     = 1'b0;
        pre_d      = '0;
        if (pre_en) begin
            tick_d = (pre_q == prescale_q);
            pre_d  = (pre_q == prescale_q) ? '0 : pre_q + PRE_W'(1);
        end
        if (wr_prescale) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prescale_q <= '0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            mode_q     <= '0;
        end else begin
            prescale_q <= prescale_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            mode_q     <= mode_d;
        end
    end

    always_comb begin
        status = '0;
        status[StatusRunLsb +: MaxCh] = run_ext;
        status[StatusIrqLsb +: MaxCh] = irq_ext;
    end

    always_comb begin
        RD_DATA = '0;
        if (is_reload_addr(RD_ADDR)) begin
            RD_DATA = reload_ext[RD_ADDR[1:0]];
        end else if (is_count_addr(RD_ADDR)) begin
            RD_DATA = count_ext[RD_ADDR[1:0]];
        end else begin
            case (RD_ADDR)
                AddrPrescale: RD_DATA = CNT_W'(prescale_q);
                AddrMode:     RD_DATA = CNT_W'(mode_q);
                AddrStatus:   RD_DATA = CNT_W'(status);
                default:      RD_DATA = '0;
            endcase
        end
    end

    assign TICK_OUT = tick_q;
    assign IRQ      = irq_ext[NUM_CH-1:0];

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: register-access vector table plus
// hand-written timing sequences for periods, one-shot, collisions and reset.
module tb_timer_scheduler;
    import timer_scheduler_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WR_EN;
    logic [3:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic [3:0]  RD_ADDR;
    logic [15:0] RD_DATA;
    logic        TICK_OUT;
    logic [3:0]  IRQ;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    timer_scheduler #(
        .NUM_CH(4),
        .CNT_W (16),
        .PRE_W (8)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .RD_ADDR (RD_ADDR),
        .RD_DATA (RD_DATA),
        .TICK_OUT(TICK_OUT),
        .IRQ     (IRQ)
    );

    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [3:0]  rd;
        logic [15:0] exp_rd;
        logic        exp_tick;
        logic [3:0]  exp_irq;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        step();
        WR_EN   = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [3:0] a, input logic [15:0] exp);
        RD_ADDR = a;
        #1;
        chk(name, 32'(RD_DATA), 32'(exp));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        WR_EN = 1'b0;
        step();
        RESET = 1'b0;
    endtask

    task automatic wait_irq(input int ch, input int limit, output int rise_cyc, output int nticks);
        int n;
        n = 0;
        nticks = TICK_OUT ? 1 : 0;
        while (IRQ[ch] !== 1'b1 && n < limit) begin
            step();
            n++;
            nticks += TICK_OUT ? 1 : 0;
        end
        rise_cyc = cyc;
        if (IRQ[ch] !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL irq%0d_timeout: got no IRQ in %0d cycles, expected a rise", ch, limit);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, r, nt;

        RESET   = 1'b1;
        WR_EN   = 1'b0;
        WR_ADDR = '0;
        WR_DATA = '0;
        RD_ADDR = '0;

        //        we    addr          data      rd          exp_rd    tick  irq
        vecs[0]  = '{1'b0, AddrPrescale, 16'h0000, AddrPrescale, 16'h0000, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, AddrPrescale, 16'h012A, AddrPrescale, 16'h002A, 1'b0, 4'h0};
        vecs[2]  = '{1'b1, AddrMode,     16'hFFF5, AddrMode,     16'h0005, 1'b0, 4'h0};
        vecs[3]  = '{1'b1, AddrReload0,  16'h1234, AddrReload0,  16'h1234, 1'b0, 4'h0};
        vecs[4]  = '{1'b1, AddrReload3,  16'hBEEF, AddrReload3,  16'hBEEF, 1'b0, 4'h0};
        vecs[5]  = '{1'b1, AddrCount0,   16'h7777, AddrCount0,   16'h0000, 1'b0, 4'h0};
        vecs[6]  = '{1'b1, 4'd13,        16'hFFFF, 4'd13,        16'h0000, 1'b0, 4'h0};
        vecs[7]  = '{1'b1, 4'd15,        16'hFFFF, 4'd15,        16'h0000, 1'b0, 4'h0};
        vecs[8]  = '{1'b0, 4'd0,         16'h0000, AddrCtrl,     16'h0000, 1'b0, 4'h0};
        vecs[9]  = '{1'b0, 4'd0,         16'h0000, AddrIrqClr,   16'h0000, 1'b0, 4'h0};
        vecs[10] = '{1'b1, AddrCtrl,     16'h0011, AddrStatus,   16'h0000, 1'b0, 4'h0};
        vecs[11] = '{1'b0, 4'd0,         16'h0000, AddrStatus,   16'h0000, 1'b0, 4'h0};
        vecs[12] = '{1'b0, 4'd0,         16'h0000, AddrCount0,   16'h0000, 1'b0, 4'h0};
        vecs[13] = '{1'b1, AddrReload2,  16'h00AA, AddrReload2,  16'h00AA, 1'b0, 4'h0};
        vecs[14] = '{1'b0, 4'd0,         16'h0000, AddrReload0,  16'h1234, 1'b0, 4'h0};

        step();
        do_reset();

        for (int i = 0; i < 15; i++) begin
            WR_EN   = vecs[i].we;
            WR_ADDR = vecs[i].addr;
            WR_DATA = vecs[i].data;
            RD_ADDR = vecs[i].rd;
            step();
            WR_EN   = 1'b0;
            chk($sformatf("vec%0d_rd", i), 32'(RD_DATA), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_tick", i), 32'(TICK_OUT), 32'(vecs[i].exp_tick));
            chk($sformatf("vec%0d_irq", i), 32'(IRQ), 32'(vecs[i].exp_irq));
        end

        // Periodic ch0: PRESCALE=3, RELOAD=2 gives one IRQ every 12 cycles.
        do_reset();
        wr(AddrPrescale, 16'd3);
        wr(AddrReload0, 16'd2);
        wr(AddrMode, 16'h0001);
        wr(AddrCtrl, 16'h0001);
        t0 = cyc;
        wait_irq(0, 40, r, nt);
        chk("a_first_period", 32'(r - t0), 32'd12);
        wr(AddrIrqClr, 16'h0001);
        chk("a_irq_cleared", 32'(IRQ), 32'h0);
        t1 = r;
        wait_irq(0, 40, r, nt);
        chk("a_second_period", 32'(r - t1), 32'd12);
        wr(AddrIrqClr, 16'h0001);
        t1 = r;
        wait_irq(0, 40, r, nt);
        chk("a_third_period", 32'(r - t1), 32'd12);
        wr(AddrCtrl, 16'h0010);
        wr(AddrIrqClr, 16'h0001);
        chk_rd("a_status_stopped", AddrStatus, 16'h0000);
        chk_rd("a_count_held", AddrCount0, 16'd2);
        for (int i = 0; i < 20; i++) step();
        chk("a_no_irq_after_stop", 32'(IRQ), 32'h0);
        chk("a_no_tick_after_stop", 32'(TICK_OUT), 32'h0);

        // One-shot ch1 with PRESCALE=0: six ticks, then idle and quiet.
        do_reset();
        wr(AddrPrescale, 16'd0);
        wr(AddrReload1, 16'd5);
        wr(AddrMode, 16'h0000);
        wr(AddrCtrl, 16'h0002);
        t0 = cyc;
        chk("b_tick_first", 32'(TICK_OUT), 32'h1);
        wait_irq(1, 40, r, nt);
        chk("b_irq_delay", 32'(r - t0), 32'd6);
        chk("b_tick_count", 32'(nt), 32'd6);
        chk_rd("b_status", AddrStatus, 16'h0020);
        chk_rd("b_count1", AddrCount1, 16'h0000);
        chk("b_tick_stopped", 32'(TICK_OUT), 32'h0);
        step();
        step();
        step();
        chk("b_tick_still_off", 32'(TICK_OUT), 32'h0);
        chk("b_irq_level", 32'(IRQ), 32'h2);

        // IRQ_CLR landing on the expiry edge loses to the set.
        do_reset();
        wr(AddrReload0, 16'd1);
        wr(AddrCtrl, 16'h0001);
        chk("c_irq_pre0", 32'(IRQ), 32'h0);
        step();
        chk("c_irq_pre1", 32'(IRQ), 32'h0);
        wr(AddrIrqClr, 16'h0001);
        chk("c_set_wins", 32'(IRQ), 32'h1);
        wr(AddrIrqClr, 16'h0001);
        chk("c_later_clear", 32'(IRQ), 32'h0);
        chk_rd("c_status_idle", AddrStatus, 16'h0000);

        // RELOAD2 changed mid-run: current period keeps 10, next uses 3.
        do_reset();
        wr(AddrReload2, 16'd10);
        wr(AddrMode, 16'h0004);
        wr(AddrCtrl, 16'h0004);
        t0 = cyc;
        step();
        step();
        wr(AddrReload2, 16'd3);
        chk_rd("d_reload2_new", AddrReload2, 16'd3);
        chk_rd("d_count2_running", AddrCount2, 16'd7);
        wait_irq(2, 40, r, nt);
        chk("d_first_period", 32'(r - t0), 32'd11);
        chk_rd("d_count2_reloaded", AddrCount2, 16'd3);
        wr(AddrIrqClr, 16'h0004);
        chk("d_irq_cleared", 32'(IRQ), 32'h0);
        t1 = r;
        wait_irq(2, 40, r, nt);
        chk("d_second_period", 32'(r - t1), 32'd4);

        // Reset with all four channels running, colliding with a CTRL write.
        do_reset();
        for (int i = 0; i < 4; i++) wr(AddrReload0 + 4'(i), 16'd100);
        wr(AddrMode, 16'h000F);
        wr(AddrCtrl, 16'h000F);
        for (int i = 0; i < 5; i++) step();
        chk_rd("e_status_running", AddrStatus, 16'h000F);
        chk("e_tick_running", 32'(TICK_OUT), 32'h1);
        RESET   = 1'b1;
        WR_EN   = 1'b1;
        WR_ADDR = AddrCtrl;
        WR_DATA = 16'h000F;
        step();
        RESET = 1'b0;
        WR_EN = 1'b0;
        chk("e_tick_reset", 32'(TICK_OUT), 32'h0);
        chk("e_irq_reset", 32'(IRQ), 32'h0);
        chk_rd("e_status_reset", AddrStatus, 16'h0000);
        chk_rd("e_prescale_reset", AddrPrescale, 16'h0000);
        chk_rd("e_mode_reset", AddrMode, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk_rd($sformatf("e_reload%0d_reset", i), AddrReload0 + 4'(i), 16'h0000);
            chk_rd($sformatf("e_count%0d_reset", i), AddrCount0 + 4'(i), 16'h0000);
        end
        for (int i = 0; i < 10; i++) step();
        chk("e_irq_quiet", 32'(IRQ), 32'h0);
        chk("e_tick_quiet", 32'(TICK_OUT), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of timer channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 16: channel counter/reload width.
REQ-003 SHALL have parameter PRE_W, default 8: shared prescaler width.
REQ-004 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port WR_EN  input  1  register write strobe, one write per cycle.
REQ-007 SHALL have port WR_ADDR  input  4  write register address.
REQ-008 SHALL have port WR_DATA  input  CNT_W  write data.
REQ-009 SHALL have port RD_ADDR  input  4  read register address.
REQ-010 SHALL have port RD_DATA  output  CNT_W  read data, combinational from RD_ADDR.
REQ-011 SHALL have port TICK_OUT  output  1  one-cycle prescaler tick pulse.
REQ-012 SHALL have port IRQ  output  NUM_CH  per-channel interrupt pending, level.

Function
REQ-013 SHALL decode addresses: 0 PRESCALE (RW), 1 CTRL (W: bits[3:0] start, bits[7:4] stop), 2 IRQ_CLR (W1C bits[3:0]), 3 MODE (RW bits[3:0], 1 = periodic, 0 = one-shot), 4..7 RELOAD ch0..3 (RW), 8..11 COUNT ch0..3 (RO), 12 STATUS (RO: bits[3:0] running, bits[7:4] IRQ).
REQ-014 SHALL return 0 on RD_DATA for unmapped addresses and for channels >= NUM_CH; writes to those SHALL be ignored.
REQ-015 SHALL run a prescaler counting 0..PRESCALE, wrapping to 0, only while at least one channel is RUN; otherwise it SHALL hold at 0.
REQ-016 SHALL assert TICK_OUT for exactly one cycle, registered, in the cycle after the prescaler equals PRESCALE while enabled; PRESCALE = 0 SHALL give a tick every cycle.
REQ-017 SHALL clear the prescaler to 0 on any write to PRESCALE.
REQ-018 SHALL keep a two-state FSM per channel: IDLE and RUN.
REQ-019 SHALL, on a start bit in IDLE or RUN, load COUNT with RELOAD and enter RUN on the next edge; a restart while in RUN is legal.
REQ-020 SHALL, on a stop bit, enter IDLE and hold COUNT; stop SHALL win over start in the same write.
REQ-021 SHALL, in RUN on TICK_OUT with COUNT != 0, decrement COUNT by 1.
REQ-022 SHALL, in RUN on TICK_OUT with COUNT == 0, set IRQ[ch] and then reload COUNT from RELOAD if periodic, or enter IDLE with COUNT = 0 if one-shot.
REQ-023 SHALL make a RELOAD write during RUN take effect only at the next reload or start.
REQ-024 SHALL, when IRQ set and IRQ_CLR occur in the same cycle, leave IRQ set (set wins).
REQ-025 SHALL, when a start and an expiry coincide, apply the start (COUNT = RELOAD, RUN) while still setting IRQ.
REQ-026 SHALL give period (RELOAD+1)*(PRESCALE+1) cycles between IRQ sets in periodic mode.

Reset
REQ-027 SHALL, on RESET, clear PRESCALE, MODE, all RELOAD/COUNT, prescaler, TICK_OUT and IRQ to 0, and set every channel to IDLE.
REQ-028 SHALL give RESET priority over any simultaneous write; RESET mid-count SHALL abort all channels with no IRQ.

Structure
REQ-029 SHALL place register address constants, CTRL/STATUS bit positions and FSM state encodings in shared package timer_scheduler_pkg.
REQ-030 SHALL implement each channel as instances of sub-module timer_channel (FSM, COUNT, RELOAD, IRQ), with the prescaler and register decode in the top level.

Verification
REQ-031 SHALL cover: PRESCALE=3, RELOAD0=2, MODE0=1, start ch0 -> IRQ[0] rises 12 cycles after start, then every 12 cycles until stop.
REQ-032 SHALL cover: one-shot, PRESCALE=0, RELOAD1=5, start ch1 -> IRQ[1] after 6 ticks, STATUS running bit 1 = 0, COUNT1 = 0, TICK_OUT stops.
REQ-033 SHALL cover: CTRL write 0x11 (start and stop ch0) -> ch0 stays IDLE, prescaler stays 0.
REQ-034 SHALL cover: IRQ_CLR=0x1 in the same cycle ch0 expires -> IRQ[0] remains 1, and a later clear drops it.
REQ-035 SHALL cover: RELOAD2 changed 10 -> 3 mid-run (periodic) -> current period uses 10, next uses 3.
REQ-036 SHALL cover: RESET asserted with 4 channels running -> all outputs 0 next cycle, no IRQ, registers read 0.
